// File: rtl/fmrv32im_axi_pkg.sv
// Shared types and AXI encodings for the fmrv32im AXI master arbiter.
//   arb_state_t       : burst sequencer states (IDLE, AR, R, AW, W, B)
//   AXI_BURST_INCR    : AxBURST encoding for incrementing bursts
//   AXI_SIZE_4B       : AxSIZE encoding for 32-bit beats
//   AXI_RESP_OKAY     : xRESP encoding for a normal response
//   AXI_CACHE_DEFAULT : AxCACHE value (bufferable, modifiable)
package fmrv32im_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/fmrv32im_axi_arbiter_if.sv
// MM_AXI bus between the arbiter (master) and the memory system (slave).
//   AR/R : read address and read data channels
//   AW/W/B : write address, write data and write response channels
//   id/size/burst/lock/cache/prot/qos/user : driven constant by the master
interface fmrv32im_axi_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic                awid,    arid;
  logic [2:0]          awsize,  arsize;
  logic [1:0]          awburst, arburst;
  logic                awlock,  arlock;
  logic [3:0]          awcache, arcache;
  logic [2:0]          awprot,  arprot;
  logic [3:0]          awqos,   arqos;
  logic                awuser,  aruser;

  modport master (
    output araddr, arlen, arvalid, rready,
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awid, arid, awsize, arsize, awburst, arburst, awlock, arlock,
    output awcache, arcache, awprot, arprot, awqos, arqos, awuser, aruser,
    input  arready, rdata, rresp, rlast, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awid, arid, awsize, arsize, awburst, arburst, awlock, arlock,
    input  awcache, arcache, awprot, arprot, awqos, arqos, awuser, aruser,
    output arready, rdata, rresp, rlast, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/fmrv32im_rr_arb2.sv
// Two-way round-robin arbiter.
//   req[0] = instruction side, req[1] = data side
//   advance : a grant is being taken this cycle; records who was served
//   gnt     : one-hot grant (combinational), zero when nobody requests
// After reset the data side counts as served last, so I wins the first tie.
module fmrv32im_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_d;

  always_comb begin
    gnt = '0;
    if (req == 2'b11) gnt = last_d ? 2'b01 : 2'b10;
    else              gnt = req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       last_d <= 1'b1;
    else if (advance) last_d <= gnt[1];
  end

endmodule

// File: rtl/fmrv32im_axi_arbiter.sv
// Shares the MM_AXI master port between the I-cache refill path (reads only)
// and the D-cache refill/writeback path (reads or writes). One burst per grant.
//   clk, rst_n          : clock, synchronous active-low reset
//   i_* / d_*           : requester side (req/addr/len, grant, read beats,
//                         write beats for D, done/err pulses)
//   mm_axi              : AXI4 master port
module fmrv32im_axi_arbiter
  import fmrv32im_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [7:0]          i_len,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rlast,
  output logic                i_done,
  output logic                i_err,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [7:0]          d_len,
  input  logic                d_we,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rlast,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_wready,
  output logic                d_done,
  output logic                d_err,
  fmrv32im_axi_arbiter_if.master mm_axi
);

  arb_state_t        state_q, state_d;
  logic [1:0]        arb_gnt;
  logic              take;
  logic              owner_q;      // 1 = data side owns the bus
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;        // beats remaining after the current one
  logic              err_q;
  logic              done_q;
  logic              done_err_q;
  logic              r_beat, w_hs, b_hs, beat_err, end_err;

  assign take = rst_n && (state_q == ST_IDLE) && (i_req || d_req);

  fmrv32im_rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({d_req, i_req}),
    .advance (take),
    .gnt     (arb_gnt)
  );

  assign r_beat = (state_q == ST_R) && mm_axi.rvalid;
  assign w_hs   = (state_q == ST_W) && mm_axi.wready;
  assign b_hs   = (state_q == ST_B) && mm_axi.bvalid;

  // A beat is bad on a non-OKAY response or when RLAST disagrees with the
  // beat count; the burst still only terminates on RLAST.
  assign beat_err = r_beat && ((mm_axi.rresp != AXI_RESP_OKAY) ||
                               (mm_axi.rlast && (cnt_q != '0)) ||
                               (!mm_axi.rlast && (cnt_q == '0)));
  assign end_err  = err_q || beat_err || (b_hs && (mm_axi.bresp != AXI_RESP_OKAY));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take) state_d = (arb_gnt[1] && d_we) ? ST_AW : ST_AR;
      ST_AR:   if (mm_axi.arready) state_d = ST_R;
      ST_R:    if (r_beat && mm_axi.rlast) state_d = ST_IDLE;
      ST_AW:   if (mm_axi.awready) state_d = ST_W;
      ST_W:    if (w_hs && (cnt_q == '0)) state_d = ST_B;
      ST_B:    if (b_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= (r_beat && mm_axi.rlast) || b_hs;
      done_err_q <= end_err;
      if (take) begin
        owner_q <= arb_gnt[1];
        addr_q  <= arb_gnt[1] ? d_addr : i_addr;
        len_q   <= arb_gnt[1] ? d_len  : i_len;
        cnt_q   <= arb_gnt[1] ? d_len  : i_len;
        err_q   <= 1'b0;
      end else begin
        // Saturate at zero so an overlong read burst keeps flagging errors.
        if ((r_beat || w_hs) && (cnt_q != '0)) cnt_q <= cnt_q - 8'd1;
        if (beat_err) err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    i_gnt    = take && arb_gnt[0];
    d_gnt    = take && arb_gnt[1];
    i_rvalid = r_beat && !owner_q;
    d_rvalid = r_beat && owner_q;
    i_rdata  = i_rvalid ? mm_axi.rdata : '0;
    d_rdata  = d_rvalid ? mm_axi.rdata : '0;
    i_rlast  = i_rvalid && mm_axi.rlast;
    d_rlast  = d_rvalid && mm_axi.rlast;
    d_wready = w_hs;
    i_done   = done_q && !owner_q;
    d_done   = done_q && owner_q;
    i_err    = i_done && done_err_q;
    d_err    = d_done && done_err_q;

    mm_axi.arvalid = (state_q == ST_AR);
    mm_axi.araddr  = addr_q;
    mm_axi.arlen   = len_q;
    mm_axi.rready  = (state_q == ST_R);
    mm_axi.awvalid = (state_q == ST_AW);
    mm_axi.awaddr  = addr_q;
    mm_axi.awlen   = len_q;
    mm_axi.wvalid  = (state_q == ST_W);
    mm_axi.wdata   = mm_axi.wvalid ? d_wdata : '0;
    mm_axi.wstrb   = mm_axi.wvalid ? d_wstrb : '0;
    mm_axi.wlast   = mm_axi.wvalid && (cnt_q == '0);
    mm_axi.bready  = (state_q == ST_B);

    mm_axi.awid    = 1'b0;
    mm_axi.arid    = 1'b0;
    mm_axi.awsize  = AXI_SIZE_4B;
    mm_axi.arsize  = AXI_SIZE_4B;
    mm_axi.awburst = AXI_BURST_INCR;
    mm_axi.arburst = AXI_BURST_INCR;
    mm_axi.awlock  = 1'b0;
    mm_axi.arlock  = 1'b0;
    mm_axi.awcache = AXI_CACHE_DEFAULT;
    mm_axi.arcache = AXI_CACHE_DEFAULT;
    mm_axi.awprot  = '0;
    mm_axi.arprot  = '0;
    mm_axi.awqos   = '0;
    mm_axi.arqos   = '0;
    mm_axi.awuser  = 1'b0;
    mm_axi.aruser  = 1'b0;
  end

endmodule

// File: doc/fmrv32im_axi_arbiter.md
# fmrv32im_axi_arbiter

Two-requester AXI4 master arbiter that shares the core's single MM_AXI master port between the instruction-cache refill path (read-only bursts) and the data-cache refill/writeback path (read or write bursts). It sits between the fmrv32im cache and the MM_AXI_* boundary of fmrv32im_core. It grants one requester at a time with round-robin priority, then sequences exactly one AXI burst (AR→R or AW→W→B) per grant.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (WSTRB = DATA_W/8)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_req / d_req  in  1  request; sampled only in IDLE
- i_addr / d_addr  in  ADDR_W  burst start address, word aligned
- i_len / d_len  in  8  beats−1 (AXI LEN encoding)
- d_we  in  1  1 = write burst
- i_gnt / d_gnt  out  1  one-cycle grant pulse; addr/len/we latched this cycle
- i_rvalid, i_rdata, i_rlast / d_rvalid, d_rdata, d_rlast  out  1/DATA_W/1  read beat to owner
- d_wdata, d_wstrb  in  DATA_W/4  current write beat; must be valid while granted write is active
- d_wready  out  1  write beat consumed this cycle; requester advances
- i_done / d_done  out  1  one-cycle end-of-transaction pulse
- i_err / d_err  out  1  valid with done; 1 = any non-OKAY resp or RLAST/beat-count mismatch
- MM_AXI_ARADDR, ARLEN, ARVALID out; ARREADY in
- MM_AXI_RDATA, RRESP, RLAST, RVALID in; RREADY out
- MM_AXI_AWADDR, AWLEN, AWVALID out; AWREADY in
- MM_AXI_WDATA, WSTRB, WLAST, WVALID out; WREADY in
- MM_AXI_BRESP, BVALID in; BREADY out
- Constant outputs: AWID/ARID=0, AWSIZE/ARSIZE=3'b010, AWBURST/ARBURST=2'b01 (INCR), LOCK=0, CACHE=4'b0011, PROT=0, QOS=0, USER=0

## Operation
- States: IDLE, AR, R, AW, W, B. Reset → IDLE.
- IDLE: if any req, grant via round robin; on simultaneous requests the requester not served last wins; after reset I wins first. Latch owner, addr, len, we (I forces we=0). Next: AR if read, AW if write.
- AR: ARVALID=1, ARADDR/ARLEN from latch, stable until ARREADY → R.
- R: RREADY=1; each RVALID beat passes combinationally to owner's rvalid/rdata/rlast (rlast = RLAST). Beat counter loads len, decrements per beat. On RLAST beat → IDLE. RRESP≠OKAY on any beat, RLAST with counter≠0, or counter=0 without RLAST sets sticky err; transaction still ends only on RLAST.
- AW: AWVALID=1 until AWREADY → W. No AW/W overlap.
- W: WVALID=1, WDATA/WSTRB = d_wdata/d_wstrb, d_wready = WREADY. WLAST=1 when counter=0. Last handshake → B.
- B: BREADY=1; on BVALID → IDLE; BRESP≠OKAY sets err.
- done/err pulse in the first IDLE cycle after the final R or B handshake; arbitration is allowed in that same cycle.
- Non-owner never sees rvalid, wready, done.

## Timing
- Reset values: all VALID/READY outputs, gnt, done, err, rvalid, d_wready = 0; address/len/data outputs = 0; last_served = D.
- Grant at cycle T → ARVALID/AWVALID at T+1.
- Read data: zero added latency (RDATA→rdata same cycle).
- Back-to-back: done at N, next gnt at N, next ARVALID/AWVALID at N+1.
- AXI VALID never drops before handshake; address/data stable while VALID high.
- rst_n low mid-burst: next edge forces IDLE, all outputs to reset values; no done issued; slave is reset with the same rst_n.

## Structure
- Package fmrv32im_axi_pkg: state enum, AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY, AXI_CACHE_DEFAULT.
- Sub-module fmrv32im_rr_arb2: 2-way round-robin arbiter (req[1:0], advance, gnt onehot, last-served flop).
- Top: FSM, latch registers, beat counter, err flag, response steering.

## Test plan
- I read, addr 0x0000_0100, len 3, slave 0-wait → ARLEN=3, four i_rvalid beats, i_rlast on 4th, i_done=1/i_err=0 one cycle later.
- D write, addr 0x0000_0800, len 0, wdata 0xDEAD_BEEF, WREADY delayed 3 cycles → WVALID held, WLAST=1, single d_wready, d_done=1.
- i_req and d_req together for 3 consecutive transactions → grants I, D, I; after reset first grant is I.
- Slave returns RRESP=2'b10 on beat 2 of len 3 read → all beats delivered, err=1 with done.
- Slave asserts RLAST on beat 2 of len 3 → transaction ends there, done with err=1.
- rst_n low during W beat 2 of len 3 → next cycle all VALIDs 0, state IDLE, no d_done.
